// File: rtl/trace_tx_if.sv
// Byte-stream link carrying serialized trace records.
//   tx_valid_o : a byte is being offered (source-driven)
//   tx_data_o  : the offered byte (source-driven)
//   tx_ready_i : the sink takes the byte this cycle (sink-driven)
// A byte moves when tx_valid_o & tx_ready_i are both high on a rising edge.
// Modports: master = byte source (trace_tx), slave = byte sink.
interface trace_tx_if;
  logic       tx_valid_o;
  logic [7:0] tx_data_o;
  logic       tx_ready_i;

  modport master (output tx_valid_o, output tx_data_o, input tx_ready_i);
  modport slave  (input tx_valid_o, input tx_data_o, output tx_ready_i);
endinterface

// File: rtl/trace_tx.sv
// trace_tx: captures one commit record per retired instruction into a small
// FIFO and serializes each record as a variable-length little-endian byte
// stream (9/13/17/21 bytes) on a valid/ready link.
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   en_i, update_i         capture enable and commit strobe
//   pc_i, instr_i          committed PC / instruction word
//   reg_addr_i, reg_data_i destination register (0 = none) and its data
//   mem_wrt_i, mem_addr_i, mem_data_i   store flag, address, data
//   tx                     byte-stream source (trace_tx_if.master)
//   level_o                records queued, including the one being sent
//   overflow_o, drop_cnt_o sticky loss flag and saturating drop counter
//   ovf_clr_i              synchronous clear of overflow_o / drop_cnt_o
module trace_tx #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   en_i,
  input  logic                   update_i,
  input  logic [XLEN-1:0]        pc_i,
  input  logic [XLEN-1:0]        instr_i,
  input  logic [4:0]             reg_addr_i,
  input  logic [XLEN-1:0]        reg_data_i,
  input  logic                   mem_wrt_i,
  input  logic [XLEN-1:0]        mem_addr_i,
  input  logic [XLEN-1:0]        mem_data_i,
  trace_tx_if.master             tx,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   overflow_o,
  output logic [CNT_W-1:0]       drop_cnt_o,
  input  logic                   ovf_clr_i
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic            mem_wrt;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
  } rec_t;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_PC, S_INSTR, S_RD, S_MADDR, S_MDATA
  } state_t;

  // Byte presented for a given field/byte-index of a record.
  function automatic logic [7:0] byte_of(state_t st, logic [1:0] idx, rec_t r);
    logic [7:0] b;
    b = 8'h00;
    case (st)
      S_HDR:   b = {r.mem_wrt, (r.reg_addr != 5'd0), 1'b1, r.reg_addr};
      S_PC:    b = r.pc[{idx, 3'b000} +: 8];
      S_INSTR: b = r.instr[{idx, 3'b000} +: 8];
      S_RD:    b = r.reg_data[{idx, 3'b000} +: 8];
      S_MADDR: b = r.mem_addr[{idx, 3'b000} +: 8];
      S_MDATA: b = r.mem_data[{idx, 3'b000} +: 8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Field following the current one; S_IDLE means the record is complete.
  function automatic state_t next_field(state_t st, rec_t r);
    state_t n;
    n = S_IDLE;
    case (st)
      S_HDR:   n = S_PC;
      S_PC:    n = S_INSTR;
      S_INSTR: n = (r.reg_addr != 5'd0) ? S_RD : (r.mem_wrt ? S_MADDR : S_IDLE);
      S_RD:    n = r.mem_wrt ? S_MADDR : S_IDLE;
      S_MADDR: n = S_MDATA;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

  rec_t mem_q [DEPTH];

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  rec_t           in_rec, head_rec, next_rec;
  logic [PTR_W:0] level;
  logic           full, empty, level_gt1;
  logic [PTR_W-1:0] rd_nxt_idx;
  logic           hs, field_done, last, pop, push_req, push, drop;
  state_t         nxt_field;

  always_comb begin
    in_rec.pc       = pc_i;
    in_rec.instr    = instr_i;
    in_rec.reg_addr = reg_addr_i;
    in_rec.reg_data = reg_data_i;
    in_rec.mem_wrt  = mem_wrt_i;
    in_rec.mem_addr = mem_addr_i;
    in_rec.mem_data = mem_data_i;
  end

  assign level      = wr_ptr_q - rd_ptr_q;
  assign full       = (level == (PTR_W+1)'(DEPTH));
  assign empty      = (level == '0);
  assign level_gt1  = (level > (PTR_W+1)'(1));
  assign rd_nxt_idx = rd_ptr_q[PTR_W-1:0] + PTR_W'(1);
  assign head_rec   = mem_q[rd_ptr_q[PTR_W-1:0]];
  // Record that becomes head after a pop. When only the head is queued, the
  // follower can only be the record being pushed in this same cycle, which
  // is not in the array yet, so take it straight from the inputs.
  assign next_rec   = level_gt1 ? mem_q[rd_nxt_idx] : in_rec;

  assign hs         = tx_valid_q & tx.tx_ready_i;
  assign field_done = (state_q == S_HDR) | (idx_q == 2'd3);
  assign nxt_field  = next_field(state_q, head_rec);
  assign last       = field_done & (nxt_field == S_IDLE);
  assign pop        = hs & last;
  assign push_req   = en_i & update_i;
  // The slot freed by a same-cycle final-byte pop may be reused at once.
  assign push       = push_req & (~full | pop);
  assign drop       = push_req & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != {CNT_W{1'b1}}) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  // state_q/idx_q name the byte currently held in tx_data_q; the next byte
  // is computed ahead so the output stays a plain register.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          state_d    = S_HDR;
          idx_d      = 2'd0;
          tx_valid_d = 1'b1;
          tx_data_d  = byte_of(S_HDR, 2'd0, head_rec);
        end
      end
      default: begin
        if (hs) begin
          if (!field_done) begin
            idx_d     = idx_q + 2'd1;
            tx_data_d = byte_of(state_q, idx_d, head_rec);
          end else if (!last) begin
            state_d   = nxt_field;
            idx_d     = 2'd0;
            tx_data_d = byte_of(nxt_field, 2'd0, head_rec);
          end else if (level_gt1 | push) begin
            state_d   = S_HDR;
            idx_d     = 2'd0;
            tx_data_d = byte_of(S_HDR, 2'd0, next_rec);
          end else begin
            state_d    = S_IDLE;
            idx_d      = 2'd0;
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Record storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= in_rec;
  end

  assign tx.tx_valid_o = tx_valid_q;
  assign tx.tx_data_o  = tx_data_q;
  assign level_o       = level;
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_trace_tx.sv
// Bench for trace_tx: stimulus pushes the hand-written byte stream of each
// record into a queue when the update is issued; a forked monitor pops and
// compares on every handshake and also checks hold-stability under stalls.
module tb_trace_tx;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0, update = 1'b0, mem_wrt = 1'b0, ovf_clr = 1'b0;
  logic [31:0] pc = '0, instr = '0, reg_data = '0, mem_addr = '0, mem_data = '0;
  logic [4:0]  reg_addr = '0;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;

  trace_tx_if tx_if();

  always #5 clk = ~clk;

  trace_tx #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .update_i(update),
    .pc_i(pc), .instr_i(instr), .reg_addr_i(reg_addr), .reg_data_i(reg_data),
    .mem_wrt_i(mem_wrt), .mem_addr_i(mem_addr), .mem_data_i(mem_data),
    .tx(tx_if), .level_o(level), .overflow_o(overflow), .drop_cnt_o(drop_cnt),
    .ovf_clr_i(ovf_clr)
  );

  logic [7:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int n_bytes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bytes are listed MSB-first in v in stream order; n is the byte count.
  task automatic push_exp(input logic [167:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
  endtask

  // Called at posedge+1; leaves update high, caller lowers it when done.
  task automatic issue(input logic [31:0] p, input logic [31:0] ins, input logic [4:0] ra,
                       input logic [31:0] rdat, input logic mw, input logic [31:0] ma,
                       input logic [31:0] md);
    pc = p; instr = ins; reg_addr = ra; reg_data = rdat;
    mem_wrt = mw; mem_addr = ma; mem_data = md;
    en = 1'b1; update = 1'b1;
    $display("issue pc=%h instr=%h rd=%0d wdata=%h st=%0b maddr=%h mdata=%h",
             p, ins, ra, rdat, mw, ma, md);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name, input bit rnd);
    int cyc = 0;
    while ((exp_q.size() != 0 || tx_if.tx_valid_o || level != 0) && cyc < 1000) begin
      if (rnd) tx_if.tx_ready_i = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    tx_if.tx_ready_i = 1'b1;
    check(name, 32'(cyc < 1000), 32'd1);
  endtask

  task automatic monitor();
    bit         stalled = 0;
    logic [7:0] held = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        stalled = 0;
      end else begin
        if (stalled) check("stall_hold", {23'd0, tx_if.tx_valid_o, tx_if.tx_data_o}, {23'd0, 1'b1, held});
        if (tx_if.tx_valid_o && tx_if.tx_ready_i) begin
          if (exp_q.size() == 0) check("unexpected_byte", {24'd0, tx_if.tx_data_o}, 32'hFFFF_FFFF);
          else check("byte", {24'd0, tx_if.tx_data_o}, {24'd0, exp_q.pop_front()});
          n_bytes++;
          $display("byte %0d: 0x%02h", n_bytes, tx_if.tx_data_o);
        end
        stalled = tx_if.tx_valid_o && !tx_if.tx_ready_i;
        held = tx_if.tx_data_o;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cyc;
    tx_if.tx_ready_i = 1'b1;
    fork monitor(); join_none

    // Reset state
    #12;
    check("rst_valid", {31'd0, tx_if.tx_valid_o}, 32'd0);
    check("rst_data", {24'd0, tx_if.tx_data_o}, 32'd0);
    check("rst_level", {28'd0, level}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    #6 rstn = 1'b1;
    @(posedge clk); #1;

    // Plain record, 9 bytes, with latency check
    push_exp(72'h20_00000080_13000000, 9);
    issue(32'h80000000, 32'h00000013, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    update = 1'b0;
    check("lat_valid_n", {31'd0, tx_if.tx_valid_o}, 32'd0);
    check("lat_level", {28'd0, level}, 32'd1);
    @(posedge clk); #1;
    check("lat_valid_n1", {31'd0, tx_if.tx_valid_o}, 32'd1);
    check("lat_hdr", {24'd0, tx_if.tx_data_o}, 32'h20);
    wait_drain("drain_a", 0);
    check("a_level", {28'd0, level}, 32'd0);

    // Register write, 13 bytes
    push_exp(104'h61_04000080_93005000_05000000, 13);
    issue(32'h80000004, 32'h00500093, 5'd1, 32'd5, 1'b0, 32'd0, 32'd0);
    update = 1'b0;
    wait_drain("drain_b", 0);

    // Store, 17 bytes
    push_exp(136'hA0_08000080_2320B500_10000080_EFBEADDE, 17);
    issue(32'h80000008, 32'h00B52023, 5'd0, 32'd0, 1'b1, 32'h80000010, 32'hDEADBEEF);
    update = 1'b0;
    wait_drain("drain_c", 0);

    // Four back-to-back records drained with random stalls
    tx_if.tx_ready_i = 1'b0;
    push_exp(72'h20_00000080_13000000, 9);
    issue(32'h80000000, 32'h00000013, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    push_exp(104'h61_04000080_93005000_05000000, 13);
    issue(32'h80000004, 32'h00500093, 5'd1, 32'd5, 1'b0, 32'd0, 32'd0);
    push_exp(136'hA0_08000080_2320B500_10000080_EFBEADDE, 17);
    issue(32'h80000008, 32'h00B52023, 5'd0, 32'd0, 1'b1, 32'h80000010, 32'hDEADBEEF);
    push_exp(168'hE3_0C000080_23A06200_78563412_00010000_0DF0FECA, 21);
    issue(32'h8000000C, 32'h0062A023, 5'd3, 32'h12345678, 1'b1, 32'h00000100, 32'hCAFEF00D);
    update = 1'b0;
    check("b2b_level", {28'd0, level}, 32'd4);
    wait_drain("drain_stall", 1);

    // Overflow: DEPTH+3 updates with the link blocked
    tx_if.tx_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      logic [7:0] lo;
      lo = 8'(4 * i);
      if (i < DEPTH) push_exp({8'h20, lo, 8'h01, 8'h00, 8'h00, 32'h13000000}, 9);
      issue(32'h00000100 + 32'(4 * i), 32'h00000013, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    end
    update = 1'b0;
    check("ovf_level", {28'd0, level}, DEPTH);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    check("ovf_drop_cnt", {16'd0, drop_cnt}, 32'd3);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("clr_flag", {31'd0, overflow}, 32'd0);
    check("clr_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("clr_level", {28'd0, level}, DEPTH);
    base = n_bytes;
    tx_if.tx_ready_i = 1'b1;
    wait_drain("drain_ovf", 0);
    check("ovf_drained_bytes", 32'(n_bytes - base), 32'(9 * DEPTH));

    // Reset in the middle of a record
    push_exp(104'h61_04000080_93005000_05000000, 13);
    base = n_bytes;
    issue(32'h80000004, 32'h00500093, 5'd1, 32'd5, 1'b0, 32'd0, 32'd0);
    update = 1'b0;
    cyc = 0;
    while (n_bytes < base + 5 && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("mid_reach", 32'(cyc < 100), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, tx_if.tx_valid_o}, 32'd0);
    check("mid_rst_level", {28'd0, level}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    push_exp(72'h20_00000080_13000000, 9);
    issue(32'h80000000, 32'h00000013, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    update = 1'b0;
    @(posedge clk); #1;
    check("post_rst_hdr", {23'd0, tx_if.tx_valid_o, tx_if.tx_data_o}, {23'd0, 1'b1, 8'h20});
    wait_drain("drain_post_rst", 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/trace_tx.md
Name: trace_tx

Overview:
- Hardware-side producer of the commit trace stream.
- Captures one record per retired instruction from core_model's commit outputs (update, pc, instr, reg_addr, reg_data, mem_addr, mem_data, mem_wrt) and buffers records in a FIFO.
- Serializes each record as variable-length little-endian bytes on a valid/ready byte interface, for a UART/debug link or a bench-side decoder.
- Decouples core commit rate from link rate and reports loss explicitly.

Parameters:
- XLEN, 32: trace field width; only 32 is supported.
- DEPTH, 8: record FIFO entries; power of two, minimum 2.
- CNT_W, 16: width of the saturating dropped-record counter.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- en_i  in  1  capture enable; when 0, update_i is ignored (not counted as a drop).
- update_i  in  1  commit strobe; one record per cycle when high.
- pc_i  in  32  committed PC.
- instr_i  in  32  committed instruction word.
- reg_addr_i  in  5  destination register; 0 means no register write.
- reg_data_i  in  32  destination write data.
- mem_wrt_i  in  1  store performed.
- mem_addr_i  in  32  store address.
- mem_data_i  in  32  store data.
- tx_valid_o  out  1  byte available.
- tx_data_o  out  8  byte value.
- tx_ready_i  in  1  sink accepts byte; handshake = tx_valid_o & tx_ready_i.
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow_o  out  1  sticky: at least one record dropped.
- drop_cnt_o  out  CNT_W  dropped records, saturating at all-ones.
- ovf_clr_i  in  1  synchronous clear of overflow_o and drop_cnt_o.

Behaviour:
- Reset (async assert, sync release):
  - tx_valid_o=0, tx_data_o=0, level_o=0, overflow_o=0, drop_cnt_o=0.
  - FIFO empty, FSM in IDLE.
  - Reset mid-record discards that record and all queued records; no partial record is resumed.
- Capture:
  - On a rising edge with en_i & update_i, push {pc, instr, reg_addr, reg_data, mem_wrt, mem_addr, mem_data}.
  - A push is accepted if the FIFO is not full, or if the final byte of the head record handshakes in the same cycle (the pop frees a slot).
  - Otherwise the record is dropped: overflow_o<=1, drop_cnt_o increments (saturating).
  - ovf_clr_i in the same cycle as a drop: clear wins, and overflow_o=0, drop_cnt_o=0 afterwards.
- Record format, in byte order:
  - HDR: {mem_wrt, rd_nz, 1'b1, reg_addr[4:0]}, where rd_nz = (reg_addr!=0). Bit 5 is always 1 (framing marker).
  - PC: 4 bytes, LSB first.
  - INSTR: 4 bytes, LSB first.
  - RD: 4 bytes of reg_data, only if rd_nz.
  - MADDR then MDATA: 4 bytes each, only if mem_wrt.
  - Record length is therefore 9, 13, 17 or 21 bytes.
- FSM states and transitions:
  - States: IDLE, HDR, PC, INSTR, RD, MADDR, MDATA; a 2-bit byte index runs 0..3 within each 4-byte field.
  - IDLE -> HDR when the FIFO is non-empty.
  - Each state advances only on handshake. Field states advance after byte index 3, skipping RD when !rd_nz and skipping MADDR/MDATA when !mem_wrt.
  - After the last byte: the head is popped. The FSM goes to HDR (back-to-back, no bubble) if the FIFO still holds a record after the pop, otherwise to IDLE.
- Valid/ready rules:
  - tx_valid_o is registered.
  - Once high, tx_valid_o and tx_data_o hold stable until handshake.
  - tx_valid_o never depends combinationally on tx_ready_i.
  - The head entry stays in place (not popped) until its last byte handshakes.
- Latency:
  - A record pushed into an empty FIFO with the FSM in IDLE at edge N gives tx_valid_o=1 with the HDR byte after edge N+1.
  - With tx_ready_i tied high, throughput is 1 byte per cycle.
- level_o:
  - Counts queued records, including the one being serialized.
  - A simultaneous push and pop leaves level_o unchanged.
  - level_o == DEPTH means full.
- FIFO pointers wrap modulo DEPTH, with an extra bit to distinguish full from empty.

Test Plan:
- Reset, then one update with pc=0x80000000, instr=0x00000013, reg_addr=0, mem_wrt=0; tx_ready=1 -> 9 bytes: 0x20, 00 00 00 80, 13 00 00 00; tx_valid drops after the 9th byte; level returns to 0.
- update with pc=0x80000004, instr=0x00500093, reg_addr=1, reg_data=5 -> 13 bytes, HDR=0x61, last 4 bytes 05 00 00 00.
- Store: reg_addr=0, mem_wrt=1, mem_addr=0x80000010, mem_data=0xDEADBEEF -> 17 bytes, HDR=0xA0, tail 10 00 00 80 EF BE AD DE.
- Random tx_ready stalls (about 50%) across 4 back-to-back records -> byte stream identical to the no-stall run; tx_data is stable whenever tx_valid=1 and tx_ready=0.
- tx_ready=0 and DEPTH+3 consecutive updates -> level=DEPTH, overflow=1, drop_cnt=3; then ovf_clr pulse -> both 0; releasing tx_ready drains exactly DEPTH records.
- Assert rstn low midway through byte 6 of a record -> tx_valid=0 immediately, level=0; after release, a new update emits a clean HDR first.
